// File: rtl/arb_pkg.sv
// Shared types and helpers for the two-way shared-datapath arbiter and its
// future N-way siblings.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic arb_state_e owner_state(input logic owner);
        return (owner == SEL_A) ? OWN_A : OWN_B;
    endfunction

    function automatic logic req_of(input logic owner, input logic ra, input logic rb);
        return (owner == SEL_A) ? ra : rb;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Saturating burst-length counter: clear to 0, load to 1, or count up to MAX_HOLD.
module hold_timer #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load1,
    input  logic inc,
    output logic sat
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sat = (cnt_q == CNT_W'(MAX_HOLD));

    // next count: clear wins over load, load wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load1) begin
            cnt_d = CNT_W'(1);
        end else if (inc && !sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux2_share_arbiter.sv
// Round-robin owner of a 2:1-muxed datapath with bounded bursts and a dead
// cycle between owners so the mux select never moves under a live grant.
module mux2_share_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic busy
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_e state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       sel_q, sel_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       busy_q, busy_d;

    logic       hold_clr_s, hold_load1_s, hold_inc_s, hold_sat_s;
    logic       enter_s, enter_owner_s;
    logic       own_req_s, oth_req_s;

    hold_timer #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hold_clr_s),
        .load1 (hold_load1_s),
        .inc   (hold_inc_s),
        .sat   (hold_sat_s)
    );

    // next-state, ownership hand-off and next output values
    always_comb begin
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        sel_d         = sel_q;
        hold_clr_s    = 1'b0;
        hold_load1_s  = 1'b0;
        hold_inc_s    = 1'b0;
        enter_s       = 1'b0;
        enter_owner_s = SEL_A;
        own_req_s     = (state_q == OWN_B) ? req_b : req_a;
        oth_req_s     = (state_q == OWN_B) ? req_a : req_b;

        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    enter_s       = 1'b1;
                    enter_owner_s = ~last_owner_q;
                end else if (req_a) begin
                    enter_s       = 1'b1;
                    enter_owner_s = SEL_A;
                end else if (req_b) begin
                    enter_s       = 1'b1;
                    enter_owner_s = SEL_B;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_A, OWN_B: begin
                if (!own_req_s) begin
                    state_d    = oth_req_s ? GAP : IDLE;
                    hold_clr_s = 1'b1;
                end else if (oth_req_s && hold_sat_s) begin
                    state_d    = GAP;
                    hold_clr_s = 1'b1;
                end else if (oth_req_s) begin
                    hold_inc_s = 1'b1;
                end else begin
                    // nobody waiting: keep the burst count pinned at 1
                    hold_load1_s = 1'b1;
                end
            end
            GAP: begin
                if (req_of(~last_owner_q, req_a, req_b)) begin
                    enter_s       = 1'b1;
                    enter_owner_s = ~last_owner_q;
                end else if (req_of(last_owner_q, req_a, req_b)) begin
                    enter_s       = 1'b1;
                    enter_owner_s = last_owner_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_clr_s = 1'b1;
            end
        endcase

        if (enter_s) begin
            state_d      = owner_state(enter_owner_s);
            sel_d        = enter_owner_s;
            last_owner_d = enter_owner_s;
            hold_load1_s = 1'b1;
        end else begin
            sel_d = sel_q;
        end

        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
        busy_d  = gnt_a_d | gnt_b_d;
    end

    // state and registered outputs; reset makes A win the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= SEL_B;
            sel_q        <= SEL_A;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            sel_q        <= sel_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign sel   = sel_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux2_share_arbiter.sv
// Directed and random checks of mux2_share_arbiter; outputs are compared as
// the 4-bit vector {gnt_a, gnt_b, sel, busy}.
module tb_mux2_share_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int WAIT_MAX = MAX_HOLD + 2;

    logic clk;
    logic rst_n;
    logic req_a, req_b;
    logic gnt_a, gnt_b, sel, busy;

    int n_vec;
    int n_err;

    mux2_share_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req_a (req_a),
        .req_b (req_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .sel   (sel),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {28'd0, gnt_a, gnt_b, sel, busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        check_vec("reset", outs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    int  wait_a, wait_b;
    logic prev_busy, prev_sel;

    initial begin
        n_vec = 0;
        n_err = 0;
        req_a = 1'b0;
        req_b = 1'b0;
        #2;
        do_reset();

        // 1: single requester, one-edge latency
        check_vec("idle", outs(), 32'h0);
        req_a = 1'b1;
        step();
        check_vec("t1_gnt_a", outs(), 32'b1001);
        req_a = 1'b0;
        step();
        check_vec("t1_release", outs(), 32'h0);

        // 2: tie from reset goes to A, forced hand-off after MAX_HOLD
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < MAX_HOLD; i++) begin
            step();
            check_vec("t2_own_a", outs(), 32'b1001);
        end
        step();
        check_vec("t2_gap_ab", outs(), 32'b0000);
        for (int i = 0; i < MAX_HOLD; i++) begin
            step();
            check_vec("t2_own_b", outs(), 32'b0111);
        end
        step();
        check_vec("t2_gap_ba", outs(), 32'b0010);
        step();
        check_vec("t2_back_a", outs(), 32'b1001);

        // 3: no pressure, A keeps the grant and the count stays at 1
        req_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_vec("t3_hold", outs(), 32'b1001);
        end
        req_b = 1'b1;
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            step();
            check_vec("t3_burst", outs(), 32'b1001);
        end
        step();
        check_vec("t3_gap", outs(), 32'b0000);
        step();
        check_vec("t3_own_b", outs(), 32'b0111);

        // B releases with A waiting -> gap then A
        req_b = 1'b0;
        step();
        check_vec("t3_gap_b_rel", outs(), 32'b0010);
        step();
        check_vec("t3_own_a", outs(), 32'b1001);

        // 4: A drops on the same edge B rises
        req_a = 1'b0;
        req_b = 1'b1;
        step();
        check_vec("t4_gap", outs(), 32'b0000);
        step();
        check_vec("t4_own_b", outs(), 32'b0111);
        step();
        check_vec("t4_hold_b", outs(), 32'b0111);

        // 5: async reset mid-burst
        rst_n = 1'b0;
        #1;
        check_vec("t5_async_rst", outs(), 32'h0);
        #4;
        rst_n = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        check_vec("t5_tie_a", outs(), 32'b1001);
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        check_vec("t5_idle", outs(), 32'b0000);

        // 6: random requests, invariant and wait-bound checks
        wait_a    = 0;
        wait_b    = 0;
        prev_busy = busy;
        prev_sel  = sel;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) req_a = ~req_a;
            if ($urandom_range(0, 3) == 0) req_b = ~req_b;
            step();
            check_vec("r_double_gnt", {31'd0, gnt_a & gnt_b}, 32'd0);
            check_vec("r_busy", {31'd0, busy}, {31'd0, gnt_a | gnt_b});
            if (busy && prev_busy) begin
                check_vec("r_sel_stable", {31'd0, sel}, {31'd0, prev_sel});
            end
            wait_a = (req_a && !gnt_a) ? wait_a + 1 : 0;
            wait_b = (req_b && !gnt_b) ? wait_b + 1 : 0;
            check_vec("r_wait_a", {31'd0, wait_a > WAIT_MAX}, 32'd0);
            check_vec("r_wait_b", {31'd0, wait_b > WAIT_MAX}, 32'd0);
            prev_busy = busy;
            prev_sel  = sel;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
